// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter: two line buffers, 3x3 window, |Gx|+|Gy|.
// Fixed 3-cycle latency, one output beat per input beat, no backpressure.
module sobel_stream_filter #(
  parameter int CD     = 8,
  parameter int WIDTH  = 640,
  parameter int THRESH = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic          in_eol,
  input  logic [CD-1:0] in_pix,
  output logic          out_valid,
  output logic          out_sof,
  output logic          out_eol,
  output logic [CD-1:0] out_pix
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = 11;
  localparam int GW = CD + 3;
  localparam int MW = CD + 4;

  localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX   = '1;
  localparam logic [MW-1:0] TH      = MW'(THRESH);
  localparam logic [MW-1:0] PIX_MAX = MW'({CD{1'b1}});

  logic [XW-1:0] x_q, x_d, x_cur;
  logic [YW-1:0] y_q, y_d, y_cur;

  logic [CD-1:0] lb0_mem [WIDTH];
  logic [CD-1:0] lb1_mem [WIDTH];
  logic [CD-1:0] lb0_rd, lb1_rd;

  logic [CD-1:0] win_q [3][3];
  logic [CD-1:0] win_d [3][3];

  logic s1_valid_q, s1_valid_d;
  logic s1_sof_q, s1_sof_d;
  logic s1_eol_q, s1_eol_d;
  logic s1_edge_q, s1_edge_d;

  logic s2_valid_q, s2_valid_d;
  logic s2_sof_q, s2_sof_d;
  logic s2_eol_q, s2_eol_d;
  logic s2_edge_q, s2_edge_d;
  logic signed [GW-1:0] gx_q, gx_d;
  logic signed [GW-1:0] gy_q, gy_d;

  logic out_valid_q, out_valid_d;
  logic out_sof_q, out_sof_d;
  logic out_eol_q, out_eol_d;
  logic [CD-1:0] out_pix_q, out_pix_d;

  logic [CD+1:0] gx_pos, gx_neg;
  logic [CD+1:0] gy_pos, gy_neg;
  logic [GW-1:0] ax, ay;
  logic [MW-1:0] mag;
  logic [CD-1:0] res;

  // in_sof overrides the stored position for the current beat only
  always_comb begin
    x_cur = in_sof ? '0 : x_q;
    y_cur = in_sof ? '0 : y_q;
    x_d   = x_q;
    y_d   = y_q;
    if (in_valid) begin
      if (in_eol || x_cur == X_LAST) begin
        x_d = '0;
        y_d = (y_cur == Y_MAX) ? y_cur : y_cur + 1'b1;
      end else begin
        x_d = x_cur + 1'b1;
        y_d = y_cur;
      end
    end
  end

  assign lb0_rd = lb0_mem[x_cur];
  assign lb1_rd = lb1_mem[x_cur];

  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1_mem[x_cur] <= lb0_rd;
      lb0_mem[x_cur] <= in_pix;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_d[r][c] = win_q[r][c];
      end
    end
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = in_pix;
    end
    s1_valid_d = in_valid;
    s1_sof_d   = in_valid & in_sof;
    s1_eol_d   = in_valid & in_eol;
    s1_edge_d  = (x_cur < XW'(2)) || (y_cur < YW'(2));
  end

  always_comb begin
    gx_pos = {2'b0, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0}
           + {2'b0, win_q[2][2]};
    gx_neg = {2'b0, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0}
           + {2'b0, win_q[2][0]};
    gy_pos = {2'b0, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0}
           + {2'b0, win_q[2][2]};
    gy_neg = {2'b0, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0}
           + {2'b0, win_q[0][2]};
    gx_d = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
    gy_d = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    s2_valid_d = s1_valid_q;
    s2_sof_d   = s1_sof_q;
    s2_eol_d   = s1_eol_q;
    s2_edge_d  = s1_edge_q;
  end

  // |G| never reaches -2^(GW-1), so the negation cannot overflow
  always_comb begin
    ax  = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
    ay  = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
    mag = {1'b0, ax} + {1'b0, ay};
    if (THRESH > 0) begin
      res = (mag >= TH) ? '1 : '0;
    end else begin
      res = (mag > PIX_MAX) ? '1 : mag[CD-1:0];
    end
    out_valid_d = s2_valid_q;
    out_sof_d   = s2_sof_q;
    out_eol_d   = s2_eol_q;
    out_pix_d   = (s2_valid_q && !s2_edge_q) ? res : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eol_q    <= 1'b0;
      s1_edge_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sof_q    <= 1'b0;
      s2_eol_q    <= 1'b0;
      s2_edge_q   <= 1'b0;
      gx_q        <= '0;
      gy_q        <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_pix_q   <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= win_d[r][c];
        end
      end
      s1_valid_q  <= s1_valid_d;
      s1_sof_q    <= s1_sof_d;
      s1_eol_q    <= s1_eol_d;
      s1_edge_q   <= s1_edge_d;
      s2_valid_q  <= s2_valid_d;
      s2_sof_q    <= s2_sof_d;
      s2_eol_q    <= s2_eol_d;
      s2_edge_q   <= s2_edge_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
      out_pix_q   <= out_pix_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;
  assign out_pix   = out_pix_q;

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Bench for sobel_stream_filter: three threshold variants fed one stream,
// checked by per-instance scoreboards against an image-level Sobel model.
module tb_sobel_stream_filter;

  localparam int W = 8;
  localparam int H = 6;

  typedef struct {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       in_eol = 1'b0;
  logic [7:0] in_pix = '0;
  logic [2:0] ov, os, oe;
  logic [7:0] op [3];

  exp_t q0[$], q1[$], q2[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mx = 0;
  int my = 0;
  int img [0:7][0:7];
  int rnd [0:7][0:7];

  function automatic int thr(input int id);
    return (id == 0) ? 0 : ((id == 1) ? 'h50 : 'h30);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sobel_stream_filter #(
      .CD(8), .WIDTH(W),
      .THRESH(g == 0 ? 0 : (g == 1 ? 'h50 : 'h30))
    ) u_dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_sof(in_sof),
      .in_eol(in_eol), .in_pix(in_pix),
      .out_valid(ov[g]), .out_sof(os[g]),
      .out_eol(oe[g]), .out_pix(op[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int id);
    return (id == 0) ? q0.size() : ((id == 1) ? q1.size() : q2.size());
  endfunction

  function automatic int pv(input int r, input int c);
    return img[my-2+r][mx-2+c];
  endfunction

  // Reference: Sobel centred one pixel up-left of the arriving pixel
  task automatic model_beat(input int p, input bit s, input bit e);
    int gx, gy, mag, v;
    bit border;
    exp_t t;
    if (s) begin
      mx = 0;
      my = 0;
    end
    if (my < 8) img[my][mx] = p;
    border = (mx < 2) || (my < 2) || (my >= 8);
    mag = 0;
    if (!border) begin
      gx = (pv(0,2) + 2*pv(1,2) + pv(2,2)) - (pv(0,0) + 2*pv(1,0) + pv(2,0));
      gy = (pv(2,0) + 2*pv(2,1) + pv(2,2)) - (pv(0,0) + 2*pv(0,1) + pv(0,2));
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    end
    for (int id = 0; id < 3; id++) begin
      if (border) v = 0;
      else if (thr(id) > 0) v = (mag >= thr(id)) ? 255 : 0;
      else v = (mag > 255) ? 255 : mag;
      t.pix = 8'(v);
      t.sof = s;
      t.eol = e;
      t.cyc = cyc + 3;
      if (id == 0) q0.push_back(t);
      else if (id == 1) q1.push_back(t);
      else q2.push_back(t);
    end
    if (e || mx == W-1) begin
      mx = 0;
      my = my + 1;
    end else begin
      mx = mx + 1;
    end
  endtask

  task automatic mon(input int id);
    exp_t t;
    if (ov[id]) begin
      if (qsize(id) == 0) begin
        chk($sformatf("unexpected_valid[%0d]", id), 1, 0);
      end else begin
        if (id == 0) t = q0.pop_front();
        else if (id == 1) t = q1.pop_front();
        else t = q2.pop_front();
        chk($sformatf("pix[%0d]", id), int'(op[id]), int'(t.pix));
        chk($sformatf("sof[%0d]", id), int'(os[id]), int'(t.sof));
        chk($sformatf("eol[%0d]", id), int'(oe[id]), int'(t.eol));
        chk($sformatf("latency_cyc[%0d]", id), cyc, t.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) mon(i);
  end

  task automatic beat(input int p, input bit s, input bit e);
    in_valid = 1'b1;
    in_pix   = 8'(p);
    in_sof   = s;
    in_eol   = e;
    model_beat(p, s, e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic idle1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit with_valid);
    reset    = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    mx       = 0;
    my       = 0;
    in_valid = with_valid;
    in_pix   = 8'h5A;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rst_valid[%0d]", i), int'(ov[i]), 0);
        chk($sformatf("rst_pix[%0d]", i), int'(op[i]), 0);
      end
      @(posedge clk);
      #1;
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("post_rst_valid[%0d]", i), int'(ov[i]), 0);
        chk($sformatf("post_rst_pix[%0d]", i), int'(op[i]), 0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int pix_of(input int kind, input int x, input int y);
    case (kind)
      0: return 'h80;
      1: return (x >= 4) ? 'hFF : 0;
      2: return (x >= 4) ? 'h10 : 0;
      default: return rnd[y][x];
    endcase
  endfunction

  task automatic send_frame(input int kind, input bit gaps, input int n);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y*W + x < n) begin
          if (gaps) begin
            while ($urandom_range(1, 0) == 1) idle1();
          end
          beat(pix_of(kind, x, y), (x == 0) && (y == 0), x == W-1);
        end
      end
    end
  endtask

  task automatic fill_rnd();
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        rnd[y][x] = int'($urandom_range(255, 0));
      end
    end
  endtask

  initial begin
    int k;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        img[y][x] = 0;
        rnd[y][x] = 0;
      end
    end
    #1;
    do_reset(1'b1);
    send_frame(0, 1'b0, W*H);
    send_frame(1, 1'b0, W*H);
    send_frame(2, 1'b0, W*H);
    send_frame(1, 1'b1, W*H);
    fill_rnd();
    send_frame(3, 1'b1, 13);
    fill_rnd();
    send_frame(3, 1'b1, W*H);
    fill_rnd();
    send_frame(3, 1'b0, W*H);
    send_frame(1, 1'b0, 21);
    do_reset(1'b0);
    send_frame(1, 1'b0, W*H);
    k = 0;
    while ((q0.size() + q1.size() + q2.size()) > 0 && k < 20) begin
      idle1();
      k++;
    end
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    chk("drain_q2", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
